ram_1port_arbiter: RTL and testbench

- Shares one single-port block RAM (registered address, registered output, 2-cycle read latency) between two requesters in the motion-update pipeline.
  - Requester 0: the position/velocity fetch stage.
  - Requester 1: the update write-back stage.
- Grants round-robin on conflict and drives the RAM address/data/write-enable ports.
- Tracks in-flight reads so returned data reaches the requester that issued it.
- Traps out-of-range addresses.

---
 rtl/ram_1port_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_1port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Tracks in-flight reads so returned data reaches its issuer; traps bad addresses.
module ram_1port_arbiter #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rd_valid0,
  output logic                  rd_valid1,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_err,
  output logic                  addr_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [WIDTH-1:0]      ram_data,
  output logic                  ram_wren,
  input  logic [WIDTH-1:0]      ram_q
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic v;
    logic id;
    logic oor;
  } trk_t;

  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      data_q;
  trk_t                  pipe_q [READ_LATENCY];
  trk_t                  push_d;
  trk_t                  out_s;

  logic                  any_g;
  logic                  sel_wr;
  logic                  sel_oor;
  logic                  sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  // Grant: lone requester wins; on conflict the one not served last wins.
  always_comb begin
    gnt0 = rst_n & req0 & (~req1 | last_q);
    gnt1 = rst_n & req1 & (~req0 | ~last_q);
    any_g = gnt0 | gnt1;
  end

  // Mux the granted requester onto the RAM; hold address/data when idle.
  always_comb begin
    sel_addr = addr_q;
    sel_data = data_q;
    sel_wr   = 1'b0;
    sel_id   = last_q;
    unique case (1'b1)
      gnt0: begin
        sel_addr = addr0;
        sel_data = wdata0;
        sel_wr   = wr0;
        sel_id   = 1'b0;
      end
      gnt1: begin
        sel_addr = addr1;
        sel_data = wdata1;
        sel_wr   = wr1;
        sel_id   = 1'b1;
      end
      default: ;
    endcase
    sel_oor     = {1'b0, sel_addr} >= LIMIT;
    ram_address = sel_addr;
    ram_data    = sel_data;
    ram_wren    = any_g & sel_wr & ~sel_oor;
  end

  // Next-state: winner memory, sticky error, tracker entry for reads.
  always_comb begin
    last_d     = any_g ? sel_id : last_q;
    err_d      = err_q | (any_g & sel_oor);
    push_d.v   = any_g & ~sel_wr;
    push_d.id  = sel_id;
    push_d.oor = sel_oor;
  end

  // State registers and the read tracker shift pipe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      err_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe_q[i] <= '0;
    end else begin
      last_q <= last_d;
      err_q  <= err_d;
      if (any_g) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      pipe_q[0] <= push_d;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Read return: route by id, zero data for invalid or out-of-range reads.
  always_comb begin
    out_s     = pipe_q[READ_LATENCY-1];
    rd_valid0 = out_s.v & ~out_s.id;
    rd_valid1 = out_s.v & out_s.id;
    rd_err    = out_s.v & out_s.oor;
    rd_data   = (out_s.v & ~out_s.oor) ? ram_q : '0;
    addr_err  = err_q;
  end

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Testbench for ram_1port_arbiter: directed plan sequences plus
// random traffic checked against a transaction-level memory model.
module tb_ram_1port_arbiter;

  localparam int W  = 16;
  localparam int D  = 200;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rd_valid0, rd_valid1, rd_err, addr_err;
  logic [W-1:0]  rd_data, ram_data, ram_q;
  logic [AW-1:0] ram_address;
  logic          ram_wren;

  always #5 clock = ~clock;

  ram_1port_arbiter #(
    .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
    .rd_data(rd_data), .rd_err(rd_err), .addr_err(addr_err),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Environment RAM: registered address, registered output.
  logic [W-1:0]  ram [256];
  logic [AW-1:0] ra;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ra    = '0;
    ram_q = '0;
  end
  always @(posedge clock) begin
    if (ram_wren) ram[ram_address] <= ram_data;
    ra    <= ram_address;
    ram_q <= ram[ra];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, last winner, sticky error, read queue.
  typedef struct {
    int           due;
    int           id;
    bit           oor;
    logic [W-1:0] d;
  } rd_t;

  logic [W-1:0]  mm [256];
  int            mlast = 1;
  bit            merr  = 0;
  logic [AW-1:0] haddr = '0;
  logic [W-1:0]  hdata = '0;
  rd_t           pq [$];
  int            cyc   = 0;

  task automatic step(input bit r0, input bit w0, input logic [7:0] a0,
                      input logic [15:0] d0, input bit r1, input bit w1,
                      input logic [7:0] a1, input logic [15:0] d1,
                      output int g);
    int           eg;
    bit           ev0, ev1, ee, ewr, eoor;
    logic [W-1:0] ed, ewd;
    logic [7:0]   ea;
    rd_t          e;
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
    g = -1;
    @(negedge clock);
    if (!rst_n) begin
      pq.delete();
      mlast = 1; merr = 0; haddr = '0; hdata = '0;
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_rdv", {rd_valid1, rd_valid0, rd_err}, 0);
      chk("rst_rdata", rd_data, 0);
      chk("rst_aerr", addr_err, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
    end else begin
      ev0 = 0; ev1 = 0; ee = 0; ed = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e = pq.pop_front();
        ev0 = (e.id == 0); ev1 = (e.id == 1);
        ee = e.oor; ed = e.d;
      end
      chk("rd_valid0", rd_valid0, ev0);
      chk("rd_valid1", rd_valid1, ev1);
      chk("rd_err", rd_err, ee);
      chk("rd_data", rd_data, ed);
      chk("addr_err", addr_err, merr);
      eg = -1;
      if (r0 && r1) eg = (mlast == 1) ? 0 : 1;
      else if (r0) eg = 0;
      else if (r1) eg = 1;
      chk("gnt0", gnt0, eg == 0);
      chk("gnt1", gnt1, eg == 1);
      if (eg >= 0) begin
        ea   = (eg == 1) ? a1 : a0;
        ewd  = (eg == 1) ? d1 : d0;
        ewr  = (eg == 1) ? w1 : w0;
        eoor = ea >= D;
        chk("ram_address", ram_address, ea);
        chk("ram_data", ram_data, ewd);
        chk("ram_wren", ram_wren, ewr && !eoor);
        haddr = ea; hdata = ewd; mlast = eg;
        if (eoor) merr = 1;
        if (ewr && !eoor) mm[ea] = ewd;
        if (!ewr) begin
          e.due = cyc + 2; e.id = eg; e.oor = eoor;
          e.d = eoor ? '0 : mm[ea];
          pq.push_back(e);
        end
      end else begin
        chk("idle_wren", ram_wren, 0);
        chk("idle_addr", ram_address, haddr);
        chk("idle_data", ram_data, hdata);
      end
      g = eg;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  int g;
  bit p0, p1, pw0, pw1;
  logic [7:0]  pa0, pa1;
  logic [15:0] pd0, pd1;

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = '0;
    rst_n = 0;
    step(1, 1, 8'h10, 16'h1111, 1, 0, 8'h20, 0, g);
    step(1, 0, 8'h10, 0, 1, 1, 8'h20, 16'h2222, g);
    rst_n = 1;

    // Write then read back from requester 0.
    step(1, 1, 8'h10, 16'hBEEF, 0, 0, 0, 0, g);
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, g);
    idle(3);

    // Seed, then contended reads alternate starting with requester 0.
    step(1, 1, 8'h02, 16'h2222, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, 1, 8'h01, 16'h1111, g);
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, g);
    idle(3);

    // Requester 1 alone: fill then back-to-back reads.
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, 1, 8'(i), 16'(16'hA0 + i), g);
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, 0, 8'(i), 0, g);
    idle(3);

    // Out-of-range write and read.
    step(1, 1, 8'h48, 16'hAAAA, 0, 0, 0, 0, g);
    step(1, 1, 8'hC8, 16'h1234, 0, 0, 0, 0, g);
    step(1, 0, 8'hC8, 0, 0, 0, 0, 0, g);
    step(1, 0, 8'h48, 0, 0, 0, 0, 0, g);
    idle(3);

    // Reset during an in-flight read drops it.
    step(1, 0, 8'h10, 0, 0, 0, 0, 0, g);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(2);
    step(1, 1, 8'h30, 16'h0C0C, 1, 1, 8'h31, 16'h0D0D, g);
    step(1, 1, 8'h30, 16'h0C0C, 1, 1, 8'h31, 16'h0D0D, g);

    // Requester 0 cancels while requester 1's write wins.
    step(1, 0, 8'h05, 0, 0, 0, 0, 0, g);
    step(1, 1, 8'h41, 16'hDEAD, 1, 1, 8'h40, 16'h5678, g);
    step(0, 0, 0, 0, 0, 0, 0, 0, g);
    step(1, 0, 8'h41, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 1, 0, 8'h40, 0, g);
    idle(3);

    // Random traffic with held requests and occasional cancels.
    p0 = 0; p1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!p0 && $urandom_range(2) == 0) begin
        p0 = 1; pw0 = $urandom_range(1) == 1;
        pa0 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
        pd0 = 16'($urandom);
      end else if (p0 && $urandom_range(9) == 0) p0 = 0;
      if (!p1 && $urandom_range(2) == 0) begin
        p1 = 1; pw1 = $urandom_range(1) == 1;
        pa1 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
        pd1 = 16'($urandom);
      end else if (p1 && $urandom_range(9) == 0) p1 = 0;
      step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end
    idle(3);
    chk("queue_drained", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
